// File: rtl/seg7_bcd_scanner.sv
// seg7_bcd_scanner
// Binary position value -> four BCD digits (sequential double-dabble),
// time-multiplexed onto a 4-anode, active-low seven-segment display.
// Optional feature macro: SEG7_LZB_EN (leading-zero blanking of digits 3..1).
module seg7_bcd_scanner #(
   parameter int VAL_W   = 14,
   parameter int CLK_DIV = 100000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [VAL_W-1:0] val,
   input  logic             val_valid,
   input  logic             disp_en,
   output logic             busy,
   output logic [3:0]       an,
   output logic [6:0]       seg
);

   localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int VMAX  = 9999;
   localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(VAL_W - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic {S_IDLE, S_CONV} state_t;

   // Values above four decimal digits saturate to 9999.
   function automatic logic [VAL_W-1:0] clamp(input logic [VAL_W-1:0] v);
      if (int'(v) > VMAX) return VAL_W'(VMAX);
      return v;
   endfunction

   // One double-dabble iteration: add 3 to every nibble >= 5, then shift in b.
   function automatic logic [15:0] dabble_step(input logic [15:0] s, input logic b);
      logic [15:0] a;
      a = s;
      for (int k = 0; k < 4; k++) begin
         if (s[4*k +: 4] >= 4'd5) a[4*k +: 4] = s[4*k +: 4] + 4'd3;
      end
      return (a << 1) | 16'(b);
   endfunction

   // Active-low gfedcba glyphs; anything outside 0..9 is dark.
   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_vld_q, pend_vld_d;
   logic [VAL_W-1:0] pend_val_q, pend_val_d;
   logic [VAL_W-1:0] bin_q, bin_d;
   logic [15:0]      bcd_q, bcd_d;
   logic [15:0]      digits_q, digits_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             tick;
   logic [3:0]       cur_digit;
   logic [3:0]       blank;

   // Converter next state: start from pending slot or strobe, iterate, publish digits.
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      cnt_d      = cnt_q;
      pend_vld_d = pend_vld_q;
      pend_val_d = pend_val_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      digits_d   = digits_q;
      case (state_q)
         S_IDLE: begin
            if (pend_vld_q) begin
               // A queued value takes precedence; a same-cycle strobe refills the slot.
               bin_d      = pend_val_q;
               bcd_d      = 16'h0000;
               cnt_d      = '0;
               busy_d     = 1'b1;
               state_d    = S_CONV;
               pend_vld_d = 1'b0;
               if (val_valid) begin
                  pend_vld_d = 1'b1;
                  pend_val_d = clamp(val);
               end
            end else if (val_valid) begin
               bin_d   = clamp(val);
               bcd_d   = 16'h0000;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_CONV;
            end
         end
         S_CONV: begin
            bcd_d = dabble_step(bcd_q, bin_q[VAL_W-1]);
            bin_d = bin_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_IT) begin
               // Final iteration result goes straight to the display register.
               digits_d = dabble_step(bcd_q, bin_q[VAL_W-1]);
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end
            if (val_valid) begin
               pend_vld_d = 1'b1;
               pend_val_d = clamp(val);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Scan divider and digit index.
   always_comb begin
      tick  = (div_q == DIV_LAST);
      div_d = tick ? '0 : div_q + 1'b1;
      idx_d = tick ? idx_q + 2'd1 : idx_q;
   end

   // Digit selected by the current scan index.
   always_comb begin
      cur_digit = digits_q[3:0];
      case (idx_q)
         2'd0: cur_digit = digits_q[3:0];
         2'd1: cur_digit = digits_q[7:4];
         2'd2: cur_digit = digits_q[11:8];
         2'd3: cur_digit = digits_q[15:12];
         default: cur_digit = digits_q[3:0];
      endcase
   end

   // Leading-zero blanking mask; the units digit is never blanked.
   always_comb begin
      blank = 4'b0000;
`ifdef SEG7_LZB_EN
      blank[3] = (digits_q[15:12] == 4'd0);
      blank[2] = blank[3] && (digits_q[11:8] == 4'd0);
      blank[1] = blank[2] && (digits_q[7:4] == 4'd0);
`else
      blank = 4'b0000;
`endif
   end

   // Next anode/cathode pattern for the current scan index.
   always_comb begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
      if (disp_en && !blank[idx_q]) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = glyph(cur_digit);
      end
   end

   // Control and display state; reset abandons any conversion and zeroes the digits.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         cnt_q      <= '0;
         pend_vld_q <= 1'b0;
         digits_q   <= 16'h0000;
         div_q      <= '0;
         idx_q      <= 2'd0;
         an_q       <= 4'b1111;
         seg_q      <= 7'b1111111;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         cnt_q      <= cnt_d;
         pend_vld_q <= pend_vld_d;
         digits_q   <= digits_d;
         div_q      <= div_d;
         idx_q      <= idx_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   // Datapath registers are only meaningful while qualified by control state.
   always_ff @(posedge clk) begin
      pend_val_q <= pend_val_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
   end

   assign busy = busy_q;
   assign an   = an_q;
   assign seg  = seg_q;

endmodule
